register_file: RTL

Two-read, one-write general-purpose register file for the single-cycle datapath. It is the consumer of the 5-bit destination-register select: it decodes the selected write address into per-register write enables and commits write-back data on the clock edge. In the same cycle it serves two combinational operand reads to the ALU path. Register 0 is hardwired to zero.

---
 rtl/register_file.sv | 80 ++++++++
 1 files changed

// File: rtl/register_file.sv
// rtl/register_file.sv - 2-read/1-write register file, r0 hardwired to zero.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    // r0 has no storage; index 0 is left out of every array below.
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS-1:1];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS-1:1];
    logic [NUM_REGS-1:1]   wr_en;
    logic [DATA_WIDTH-1:0] stored1;
    logic [DATA_WIDTH-1:0] stored2;

    always_comb begin
        wr_en = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            wr_en[i] = reg_write && (write_reg == ADDR_WIDTH'(i));
        end
    end

    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (wr_en[i]) begin
                regs_d[i] = write_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read muxes see only stored state, keeping the write decode off the read path.
    always_comb begin
        stored1 = '0;
        stored2 = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (read_reg1 == ADDR_WIDTH'(i)) stored1 = regs_q[i];
            if (read_reg2 == ADDR_WIDTH'(i)) stored2 = regs_q[i];
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd1;
    logic fwd2;

    assign fwd1 = rst_n && reg_write && (write_reg != '0) && (write_reg == read_reg1);
    assign fwd2 = rst_n && reg_write && (write_reg != '0) && (write_reg == read_reg2);
    assign read_data1 = fwd1 ? write_data : stored1;
    assign read_data2 = fwd2 ? write_data : stored2;
`else
    assign read_data1 = stored1;
    assign read_data2 = stored2;
`endif

    a_write_addr_known: assert property (
        @(posedge clk) disable iff (!rst_n) reg_write |-> !$isunknown(write_reg)
    );

endmodule
